// File: rtl/cmt_retire_pkg.sv
// Shared definitions for the commit/retire stage: the per-slot commit request,
// exception codes, the retire FSM states and the default exception vector.
// The optional performance counters are enabled with the CMT_PERF_EN macro.
package cmt_retire_pkg;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  localparam logic [4:0] EXCCODE_ADEL = 5'd4;
  localparam logic [4:0] EXCCODE_ADES = 5'd5;
  localparam logic [4:0] EXCCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCCODE_OV   = 5'd12;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} cmt_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        hilo_we;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        exc;
    logic [4:0]  exccode;
    logic [31:0] badvaddr;
    logic        is_eret;
    logic        in_ds;
  } cmt_req_t;

  // Only address-error exceptions latch a faulting address into BadVAddr.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXCCODE_ADEL) || (code == EXCCODE_ADES);
  endfunction

endpackage

// File: rtl/cmt_retire_if.sv
// Commit-stage bus: the two commit slots plus stall coming in, and the
// regfile / HI-LO writeback and flush/redirect going out.
interface cmt_retire_if;
  import cmt_retire_pkg::*;

  logic                  stall;
  cmt_req_t [1:0]        cmt_in;
  logic [1:0]            rf_we;
  logic [1:0][4:0]       rf_waddr;
  logic [1:0][31:0]      rf_wdata;
  logic                  hilo_we;
  logic [31:0]           hi_o;
  logic [31:0]           lo_o;
  logic                  flush;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;

  modport master (
    output stall, cmt_in,
    input  rf_we, rf_waddr, rf_wdata, hilo_we, hi_o, lo_o,
           flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  stall, cmt_in,
    output rf_we, rf_waddr, rf_wdata, hilo_we, hi_o, lo_o,
           flush, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/cmt_slot_mask.sv
// Combinational kill-point detection and same-cycle write-after-write masking
// for the two commit slots (slot0 is older than slot1).
module cmt_slot_mask (
  input  logic            retire_en_i,
  input  logic [1:0]      valid_i,
  input  logic [1:0]      kill_i,
  input  logic [1:0]      we_i,
  input  logic [1:0][4:0] waddr_i,
  output logic [1:0]      retire_o,
  output logic [1:0]      rf_we_o,
  output logic            kill_vld_o,
  output logic            kill_sel_o
);

  logic [1:0] ev;
  logic [1:0] wr;

  // A slot retires only if no older-or-same slot raises a kill event.
  always_comb begin
    ev            = valid_i & kill_i;
    retire_o      = '0;
    retire_o[0]   = retire_en_i & valid_i[0] & ~ev[0];
    retire_o[1]   = retire_en_i & valid_i[1] & ~ev[0] & ~ev[1];
    wr[0]         = retire_o[0] & we_i[0] & (waddr_i[0] != 5'd0);
    wr[1]         = retire_o[1] & we_i[1] & (waddr_i[1] != 5'd0);
    rf_we_o       = '0;
    rf_we_o[1]    = wr[1];
    rf_we_o[0]    = wr[0] & ~(wr[1] & (waddr_i[1] == waddr_i[0]));
    kill_vld_o    = retire_en_i & (ev[0] | ev[1]);
    kill_sel_o    = ~ev[0];
  end

endmodule

// File: rtl/cmt_retire.sv
// Commit stage: retires up to two instructions per cycle, records the
// exception frame and issues a one-cycle flush/redirect on exception or ERET.
// Define CMT_PERF_EN to add the retire_cnt / exc_cnt performance counters.
module cmt_retire
  import cmt_retire_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int          SLOTS      = 2
) (
  input  logic        clk,
  input  logic        rst,
  cmt_retire_if.slave bus,
  output logic [31:0] epc_o,
  output logic [4:0]  cause_exccode,
  output logic        cause_bd,
  output logic        status_exl,
  output logic [31:0] badvaddr_o
`ifdef CMT_PERF_EN
  ,
  output logic [31:0] retire_cnt,
  output logic [15:0] exc_cnt
`endif
);

  if (SLOTS != 2) begin : g_slots_check
    $error("cmt_retire supports exactly two slots");
  end

  cmt_state_t  state_q, state_d;
  logic        flush_q, flush_d;
  logic        rv_q, rv_d;
  logic [31:0] rpc_q, rpc_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  code_q, code_d;
  logic        bd_q, bd_d;
  logic        exl_q, exl_d;
  logic [31:0] bad_q, bad_d;

  logic            retire_en;
  logic [1:0]      valid, kill, we, retire, rf_we, hw;
  logic [1:0][4:0] waddr;
  logic            kill_vld, kill_sel;
  cmt_req_t        ks;

  // Reset is folded in so the combinational write strobes are also quiet in reset.
  assign retire_en = (state_q == RUN) & ~bus.stall & ~rst;

  // Unpack the per-slot fields the masking logic needs.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      valid[i] = bus.cmt_in[i].valid;
      kill[i]  = bus.cmt_in[i].exc | bus.cmt_in[i].is_eret;
      we[i]    = bus.cmt_in[i].we;
      waddr[i] = bus.cmt_in[i].waddr;
    end
  end

  cmt_slot_mask u_mask (
    .retire_en_i (retire_en),
    .valid_i     (valid),
    .kill_i      (kill),
    .we_i        (we),
    .waddr_i     (waddr),
    .retire_o    (retire),
    .rf_we_o     (rf_we),
    .kill_vld_o  (kill_vld),
    .kill_sel_o  (kill_sel)
  );

  assign ks = kill_sel ? bus.cmt_in[1] : bus.cmt_in[0];

  // Regfile and HI/LO writeback; data is zeroed when its strobe is low.
  always_comb begin
    bus.rf_we    = rf_we;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    for (int i = 0; i < 2; i++) begin
      if (rf_we[i]) begin
        bus.rf_waddr[i] = bus.cmt_in[i].waddr;
        bus.rf_wdata[i] = bus.cmt_in[i].wdata;
      end
    end
    hw[0]       = retire[0] & bus.cmt_in[0].hilo_we;
    hw[1]       = retire[1] & bus.cmt_in[1].hilo_we;
    bus.hilo_we = |hw;
    bus.hi_o    = '0;
    bus.lo_o    = '0;
    if (hw[0]) begin
      bus.hi_o = bus.cmt_in[0].hi;
      bus.lo_o = bus.cmt_in[0].lo;
    end
    if (hw[1]) begin
      bus.hi_o = bus.cmt_in[1].hi;
      bus.lo_o = bus.cmt_in[1].lo;
    end
  end

  // FSM next state and exception-frame updates for the kill event.
  always_comb begin
    state_d = state_q;
    flush_d = 1'b0;
    rv_d    = 1'b0;
    rpc_d   = rpc_q;
    epc_d   = epc_q;
    code_d  = code_q;
    bd_d    = bd_q;
    exl_d   = exl_q;
    bad_d   = bad_q;
    if (state_q == FLUSH) begin
      state_d = RUN;
    end else if (kill_vld) begin
      state_d = FLUSH;
      flush_d = 1'b1;
      rv_d    = 1'b1;
      if (ks.exc) begin
        if (!exl_q) begin
          epc_d = ks.in_ds ? (ks.pc - 32'd4) : ks.pc;
          bd_d  = ks.in_ds;
        end
        code_d = ks.exccode;
        exl_d  = 1'b1;
        if (is_addr_exc(ks.exccode)) bad_d = ks.badvaddr;
        rpc_d  = EXC_VECTOR;
      end else begin
        exl_d = 1'b0;
        rpc_d = epc_q;
      end
    end
  end

  // State and exception-frame registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      flush_q <= 1'b0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
      epc_q   <= '0;
      code_q  <= '0;
      bd_q    <= 1'b0;
      exl_q   <= 1'b0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
      epc_q   <= epc_d;
      code_q  <= code_d;
      bd_q    <= bd_d;
      exl_q   <= exl_d;
      bad_q   <= bad_d;
    end
  end

  assign bus.flush          = flush_q;
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = rpc_q;
  assign epc_o              = epc_q;
  assign cause_exccode      = code_q;
  assign cause_bd           = bd_q;
  assign status_exl         = exl_q;
  assign badvaddr_o         = bad_q;

`ifdef CMT_PERF_EN
  logic [31:0] rcnt_q;
  logic [15:0] ecnt_q;

  // Retired-instruction and taken-exception counters, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt_q <= '0;
      ecnt_q <= '0;
    end else begin
      rcnt_q <= rcnt_q + 32'(retire[0]) + 32'(retire[1]);
      if (kill_vld && ks.exc) ecnt_q <= ecnt_q + 16'd1;
    end
  end

  assign retire_cnt = rcnt_q;
  assign exc_cnt    = ecnt_q;
`endif

endmodule

// File: tb/tb_cmt_retire.sv
// Self-checking bench for cmt_retire: directed scenarios followed by random
// traffic, all compared against a slot-by-slot behavioural model.
module tb_cmt_retire;
  import cmt_retire_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmt_retire_if bus();

  logic [31:0] epc_o, badvaddr_o;
  logic [4:0]  cause_exccode;
  logic        cause_bd, status_exl;
`ifdef CMT_PERF_EN
  logic [31:0] retire_cnt;
  logic [15:0] exc_cnt;
`endif

  cmt_retire dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .epc_o         (epc_o),
    .cause_exccode (cause_exccode),
    .cause_bd      (cause_bd),
    .status_exl    (status_exl),
    .badvaddr_o    (badvaddr_o)
`ifdef CMT_PERF_EN
    ,
    .retire_cnt    (retire_cnt),
    .exc_cnt       (exc_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Architectural model state
  bit          m_inflush;
  logic        m_flush, m_rv, m_bd, m_exl;
  logic [31:0] m_rpc, m_epc, m_bad, m_rcnt;
  logic [4:0]  m_code;
  logic [15:0] m_ecnt;

  // Expected combinational outputs
  logic [1:0]       e_we;
  logic [1:0][4:0]  e_waddr;
  logic [1:0][31:0] e_wdata;
  logic             e_hw;
  logic [31:0]      e_hi, e_lo;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_inflush = 0; m_flush = 0; m_rv = 0; m_bd = 0; m_exl = 0;
    m_rpc = 0; m_epc = 0; m_bad = 0; m_code = 0; m_rcnt = 0; m_ecnt = 0;
  endtask

  // Walk the slots in program order: instructions retire until the first
  // exception/ERET; the regfile keeps only the youngest write per register.
  task automatic predict(output int kslot, output logic [1:0] ret);
    bit en, stop;
    logic [1:0] wr;
    kslot = 2; ret = '0; stop = 0;
    en = !rst && !m_inflush && !bus.stall;
    if (en) begin
      for (int i = 0; i < 2; i++) begin
        if (!stop && bus.cmt_in[i].valid) begin
          if (bus.cmt_in[i].exc || bus.cmt_in[i].is_eret) begin
            kslot = i; stop = 1;
          end else begin
            ret[i] = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < 2; i++)
      wr[i] = ret[i] && bus.cmt_in[i].we && (bus.cmt_in[i].waddr != 5'd0);
    e_we = '0; e_waddr = '0; e_wdata = '0;
    for (int i = 0; i < 2; i++) begin
      bit overwritten;
      overwritten = 0;
      for (int j = i + 1; j < 2; j++)
        if (wr[j] && bus.cmt_in[j].waddr == bus.cmt_in[i].waddr) overwritten = 1;
      if (wr[i] && !overwritten) begin
        e_we[i] = 1'b1;
        e_waddr[i] = bus.cmt_in[i].waddr;
        e_wdata[i] = bus.cmt_in[i].wdata;
      end
    end
    e_hw = 0; e_hi = 0; e_lo = 0;
    for (int i = 0; i < 2; i++)
      if (ret[i] && bus.cmt_in[i].hilo_we) begin
        e_hw = 1; e_hi = bus.cmt_in[i].hi; e_lo = bus.cmt_in[i].lo;
      end
  endtask

  task automatic check_all();
    int k;
    logic [1:0] r;
    predict(k, r);
    chk("rf_we",          bus.rf_we,          e_we);
    chk("rf_waddr",       bus.rf_waddr,       e_waddr);
    chk("rf_wdata",       bus.rf_wdata,       e_wdata);
    chk("hilo_we",        bus.hilo_we,        e_hw);
    chk("hi_o",           bus.hi_o,           e_hi);
    chk("lo_o",           bus.lo_o,           e_lo);
    chk("flush",          bus.flush,          m_flush);
    chk("redirect_valid", bus.redirect_valid, m_rv);
    chk("redirect_pc",    bus.redirect_pc,    m_rpc);
    chk("epc",            epc_o,              m_epc);
    chk("exccode",        cause_exccode,      m_code);
    chk("bd",             cause_bd,           m_bd);
    chk("exl",            status_exl,         m_exl);
    chk("badvaddr",       badvaddr_o,         m_bad);
`ifdef CMT_PERF_EN
    chk("retire_cnt",     retire_cnt,         m_rcnt);
    chk("exc_cnt",        exc_cnt,            m_ecnt);
`endif
  endtask

  task automatic settle();
    #4;
    check_all();
  endtask

  // Apply one clock of the model, then move to just after the edge.
  task automatic advance();
    int k;
    logic [1:0] r;
    cmt_req_t q;
    predict(k, r);
    m_rcnt = m_rcnt + 32'(r[0]) + 32'(r[1]);
    if (m_inflush) begin
      m_inflush = 0; m_flush = 0; m_rv = 0;
    end else if (k < 2) begin
      q = bus.cmt_in[k];
      m_inflush = 1; m_flush = 1; m_rv = 1;
      if (q.exc) begin
        if (!m_exl) begin
          m_epc = q.in_ds ? q.pc - 32'd4 : q.pc;
          m_bd  = q.in_ds;
        end
        m_code = q.exccode;
        m_exl  = 1;
        if (q.exccode == 5'd4 || q.exccode == 5'd5) m_bad = q.badvaddr;
        m_rpc  = 32'hBFC0_0380;
        m_ecnt = m_ecnt + 16'd1;
      end else begin
        m_rpc = m_epc;
        m_exl = 0;
      end
    end else begin
      m_flush = 0; m_rv = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.cmt_in = '0;
    bus.stall  = 1'b0;
  endtask

  task automatic rnd_slot(input int i);
    cmt_req_t r;
    logic [31:0] t;
    logic [4:0] codes [4];
    codes[0] = 5'd4; codes[1] = 5'd5; codes[2] = 5'd12; codes[3] = 5'd8;
    t = $urandom;
    r = '0;
    r.valid    = ($urandom_range(0, 3) != 0);
    r.pc       = {t[31:2], 2'b00};
    r.we       = 1'($urandom_range(0, 1));
    r.waddr    = 5'($urandom_range(0, 7));
    r.wdata    = $urandom;
    r.hilo_we  = ($urandom_range(0, 2) == 0);
    r.hi       = $urandom;
    r.lo       = $urandom;
    r.exc      = ($urandom_range(0, 9) == 0);
    r.exccode  = codes[$urandom_range(0, 3)];
    r.badvaddr = $urandom;
    r.is_eret  = ($urandom_range(0, 11) == 0);
    r.in_ds    = 1'($urandom_range(0, 1));
    bus.cmt_in[i] = r;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    settle();
    chk("reset_flush", bus.flush, 1'b0);
    rst = 1'b0;
    advance();

    // Two independent writes
    bus.cmt_in[0].valid = 1; bus.cmt_in[0].we = 1; bus.cmt_in[0].waddr = 5'd3;
    bus.cmt_in[0].wdata = 32'hAAAA_0001; bus.cmt_in[0].pc = 32'h8000_0000;
    bus.cmt_in[1].valid = 1; bus.cmt_in[1].we = 1; bus.cmt_in[1].waddr = 5'd7;
    bus.cmt_in[1].wdata = 32'hBBBB_0002; bus.cmt_in[1].pc = 32'h8000_0004;
    bus.cmt_in[1].hilo_we = 1; bus.cmt_in[1].hi = 32'h1111; bus.cmt_in[1].lo = 32'h2222;
    bus.cmt_in[0].hilo_we = 1; bus.cmt_in[0].hi = 32'h3333; bus.cmt_in[0].lo = 32'h4444;
    settle();
    chk("t1_we", bus.rf_we, 2'b11);
    chk("t1_wdata1", bus.rf_wdata[1], 32'hBBBB_0002);
    chk("t1_hi_slot1", bus.hi_o, 32'h1111);
    advance();

    // WAW and r0 suppression
    bus.cmt_in[0].waddr = 5'd5; bus.cmt_in[1].waddr = 5'd5;
    settle();
    chk("t2_waw_we", bus.rf_we, 2'b10);
`ifdef CMT_PERF_EN
    chk("perf_after_pair", retire_cnt, 32'd2);
`endif
    advance();
    bus.cmt_in[0].waddr = 5'd0; bus.cmt_in[1].waddr = 5'd9;
    settle();
    chk("t2_r0_we", bus.rf_we, 2'b10);
    advance();

    // Exception in a delay slot
    clr();
    bus.cmt_in[0].valid = 1; bus.cmt_in[0].exc = 1; bus.cmt_in[0].exccode = EXCCODE_OV;
    bus.cmt_in[0].pc = 32'h8000_1000; bus.cmt_in[0].in_ds = 1;
    bus.cmt_in[1].valid = 1; bus.cmt_in[1].we = 1; bus.cmt_in[1].waddr = 5'd6;
    bus.cmt_in[1].wdata = 32'hDEAD_BEEF;
    settle();
    chk("t3_we", bus.rf_we, 2'b00);
    advance();
    settle();
    chk("t3_flush", bus.flush, 1'b1);
    chk("t3_rpc", bus.redirect_pc, 32'hBFC0_0380);
    chk("t3_epc", epc_o, 32'h8000_0FFC);
    chk("t3_bd", cause_bd, 1'b1);
    chk("t3_exl", status_exl, 1'b1);
    advance();
    clr();
    settle();
    chk("t3_flush_low", bus.flush, 1'b0);

    // Nested address error with EXL already set
    bus.cmt_in[0].valid = 1; bus.cmt_in[0].we = 1; bus.cmt_in[0].waddr = 5'd2;
    bus.cmt_in[0].wdata = 32'h0000_0022; bus.cmt_in[0].pc = 32'h8000_3000;
    bus.cmt_in[1].valid = 1; bus.cmt_in[1].exc = 1; bus.cmt_in[1].exccode = EXCCODE_ADEL;
    bus.cmt_in[1].badvaddr = 32'h0000_1234; bus.cmt_in[1].pc = 32'h8000_3004;
    settle();
    chk("t4_we", bus.rf_we, 2'b01);
    advance();
    settle();
    chk("t4_epc", epc_o, 32'h8000_0FFC);
    chk("t4_code", cause_exccode, 5'd4);
    chk("t4_bad", badvaddr_o, 32'h0000_1234);
    clr();
    advance();

    // ERET to clear EXL, then an exception to load EPC=0x80002000
    bus.cmt_in[0].valid = 1; bus.cmt_in[0].is_eret = 1;
    settle();
    advance();
    settle();
    chk("t5a_exl", status_exl, 1'b0);
    clr();
    advance();
    bus.cmt_in[0].valid = 1; bus.cmt_in[0].exc = 1; bus.cmt_in[0].exccode = EXCCODE_SYS;
    bus.cmt_in[0].pc = 32'h8000_2000;
    settle();
    advance();
    clr();
    settle();
    chk("t5b_epc", epc_o, 32'h8000_2000);
    advance();
    bus.cmt_in[0].valid = 1; bus.cmt_in[0].is_eret = 1;
    bus.cmt_in[1].valid = 1; bus.cmt_in[1].we = 1; bus.cmt_in[1].waddr = 5'd4;
    settle();
    chk("t5_we", bus.rf_we, 2'b00);
    advance();
    settle();
    chk("t5_exl", status_exl, 1'b0);
    chk("t5_rv", bus.redirect_valid, 1'b1);
    chk("t5_rpc", bus.redirect_pc, 32'h8000_2000);
    clr();
    advance();

    // Stalled exception is taken once after stall drops
    bus.stall = 1;
    bus.cmt_in[0].valid = 1; bus.cmt_in[0].exc = 1; bus.cmt_in[0].exccode = EXCCODE_OV;
    bus.cmt_in[0].pc = 32'h8000_4000;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("t6_stall_flush", bus.flush, 1'b0);
      advance();
    end
    bus.stall = 0;
    settle();
    advance();
    settle();
    chk("t6_flush", bus.flush, 1'b1);
    chk("t6_epc", epc_o, 32'h8000_4000);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    chk("t6_rst_flush", bus.flush, 1'b0);
    chk("t6_rst_rv", bus.redirect_valid, 1'b0);
    chk("t6_rst_exl", status_exl, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr();
    advance();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rnd_slot(0);
      rnd_slot(1);
      bus.stall = ($urandom_range(0, 4) == 0);
      settle();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
